// File: rtl/sau_digit_mac_if.sv
// Handshake bundle for sau_digit_mac: tap input stream and accumulated-sum output stream.
interface sau_digit_mac_if #(
  parameter int unsigned WIDTH  = 20,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned ACC_W  = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [WIDTH-1:0]  in_sample;
  logic signed [COEF_W-1:0] in_coef;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;

  modport master (
    output in_valid, in_sample, in_coef, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sample, in_coef, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sau_digit_mac.sv
// Radix-8 serial multiply-accumulate: octal coefficient digits (MSB first) select
// shift-and-add sample multiples from an internal sau, products summed until in_last.
module sau #(
  parameter int unsigned WIDTH = 20
) (
  input  logic signed [WIDTH-1:0] smp,
  output logic signed [WIDTH+2:0] m_c [8]
);
  localparam int unsigned MW = WIDTH + 3;

  logic signed [MW-1:0] x1;
  logic signed [MW-1:0] x2;
  logic signed [MW-1:0] x4;
  logic signed [MW-1:0] x8;

  assign x1 = MW'(smp);
  assign x2 = x1 <<< 1;
  assign x4 = x1 <<< 2;
  assign x8 = x1 <<< 3;

  // m_c[k] = (k+1) * smp using shifts and a single add/sub each
  assign m_c[0] = x1;
  assign m_c[1] = x2;
  assign m_c[2] = x2 + x1;
  assign m_c[3] = x4;
  assign m_c[4] = x4 + x1;
  assign m_c[5] = x4 + x2;
  assign m_c[6] = x8 - x1;
  assign m_c[7] = x8;
endmodule

module sau_digit_mac #(
  parameter int unsigned WIDTH  = 20,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned ACC_W  = 32
) (
  input logic               clk,
  input logic               rst_n,
  sau_digit_mac_if.slave    bus
);
  localparam int unsigned NDIG  = (COEF_W + 2) / 3;
  localparam int unsigned DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned PW    = WIDTH + COEF_W;
  localparam int unsigned MW    = WIDTH + 3;
  localparam int unsigned PADW  = 3 * NDIG;

  typedef enum logic [1:0] {IDLE, DIGIT, ACC, DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [WIDTH-1:0]  smp_q, smp_d;
  logic [COEF_W-1:0]        mag_q, mag_d;
  logic                     neg_q, neg_d;
  logic                     last_q, last_d;
  logic signed [PW-1:0]     part_q, part_d;
  logic [DIG_W-1:0]         dig_q, dig_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  out_data_q, out_data_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [MW-1:0]     m_c [8];
  logic [PADW-1:0]          mag_pad_c;
  logic [2:0]               digit_c;
  logic signed [PW-1:0]     term_c;
  logic signed [ACC_W-1:0]  part_ext_c;
  logic signed [ACC_W-1:0]  acc_sum_c;

  sau #(.WIDTH(WIDTH)) u_sau (
    .smp (smp_q),
    .m_c (m_c)
  );

  // Current octal digit of the magnitude and the multiple it selects
  always_comb begin
    mag_pad_c  = PADW'(mag_q);
    digit_c    = 3'(mag_pad_c >> (32'(dig_q) * 32'd3));
    term_c     = '0;
    if (digit_c != 3'd0) begin
      term_c = PW'(m_c[digit_c - 3'd1]);
    end
    part_ext_c = ACC_W'(part_q);
    acc_sum_c  = neg_q ? (acc_q - part_ext_c) : (acc_q + part_ext_c);
  end

  always_comb begin
    state_d    = state_q;
    smp_d      = smp_q;
    mag_d      = mag_q;
    neg_d      = neg_q;
    last_d     = last_q;
    part_d     = part_q;
    dig_d      = dig_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          smp_d   = bus.in_sample;
          neg_d   = bus.in_coef[COEF_W-1];
          mag_d   = bus.in_coef[COEF_W-1] ? (~bus.in_coef + 1'b1) : bus.in_coef;
          last_d  = bus.in_last;
          part_d  = '0;
          dig_d   = DIG_W'(NDIG - 1);
          state_d = DIGIT;
        end
      end
      DIGIT: begin
        part_d = (part_q <<< 3) + term_c;
        if (dig_q == '0) begin
          state_d = ACC;
        end else begin
          dig_d = dig_q - 1'b1;
        end
      end
      ACC: begin
        if (last_q) begin
          out_data_d = acc_sum_c;
          acc_d      = '0;
          state_d    = DONE;
        end else begin
          acc_d   = acc_sum_c;
          state_d = IDLE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags are registered copies of the next-state decode
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      smp_q       <= '0;
      mag_q       <= '0;
      neg_q       <= 1'b0;
      last_q      <= 1'b0;
      part_q      <= '0;
      dig_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      smp_q       <= smp_d;
      mag_q       <= mag_d;
      neg_q       <= neg_d;
      last_q      <= last_d;
      part_q      <= part_d;
      dig_q       <= dig_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_sau_digit_mac.sv
// Bench for sau_digit_mac: directed and random tap sequences against a plain-arithmetic sum model.
module tb_sau_digit_mac;
  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;
  int   ov_rises;
  logic ov_prev;

  sau_digit_mac_if #(.WIDTH(20), .COEF_W(8), .ACC_W(32)) bus ();
  sau_digit_mac_if #(.WIDTH(20), .COEF_W(8), .ACC_W(16)) bus16 ();

  sau_digit_mac #(.WIDTH(20), .COEF_W(8), .ACC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sau_digit_mac #(.WIDTH(20), .COEF_W(8), .ACC_W(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid && !ov_prev) ov_rises++;
    ov_prev = bus.out_valid;
  end

  task automatic send(input logic signed [19:0] s, input logic signed [7:0] c,
                      input logic l, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%0b required=1", bus.in_ready);
    end
    bus.in_sample = s;
    bus.in_coef   = c;
    bus.in_last   = l;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic recv(output logic signed [31:0] val, output int lat, output int rdy_hi);
    int n;
    n = 0;
    rdy_hi = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 200) begin
      if (bus.in_ready) rdy_hi++;
      @(negedge clk);
      n++;
    end
    if (bus.in_ready) rdy_hi++;
    lat = cyc;
    if (!bus.out_valid) begin
      checks++; errors++;
      $display("FAIL recv_timeout out_valid=%0b required=1", bus.out_valid);
    end
    val = bus.out_data;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 32'sd0) begin
      errors++; $display("FAIL reset_out_data got=%0d exp=0", bus.out_data);
    end
  endtask

  task automatic test_single();
    int a, lat, hi;
    logic signed [31:0] v;
    send(20'sd1000, 8'sd90, 1'b1, a);
    recv(v, lat, hi);
    checks++;
    if (v !== 32'sd90000) begin
      errors++; $display("FAIL single_data got=%0d exp=90000", v);
    end
    checks++;
    if (lat - a !== 4) begin
      errors++; $display("FAIL single_latency got=%0d exp=4 edges after accept", lat - a);
    end
    checks++;
    if (hi !== 0) begin
      errors++; $display("FAIL single_in_ready_low got=%0d high cycles exp=0", hi);
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_release got in_ready=%0b out_valid=%0b exp 1/0",
                         bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_corners();
    int a, lat, hi;
    logic signed [31:0] v;
    send(-20'sd3, -8'sd128, 1'b1, a);
    recv(v, lat, hi);
    checks++;
    if (v !== 32'sd384) begin
      errors++; $display("FAIL corner_min_coef got=%0d exp=384", v);
    end
    send(20'sd524287, 8'sd127, 1'b1, a);
    recv(v, lat, hi);
    checks++;
    if (v !== 32'sd66584449) begin
      errors++; $display("FAIL corner_max got=%0d exp=66584449", v);
    end
    send(20'sd524287, 8'sd0, 1'b1, a);
    recv(v, lat, hi);
    checks++;
    if (v !== 32'sd0) begin
      errors++; $display("FAIL corner_zero_coef got=%0d exp=0", v);
    end
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2, a3, lat, hi, r0;
    logic signed [31:0] v;
    r0 = ov_rises;
    send(20'sd10, 8'sd64, 1'b0, a0);
    send(-20'sd20, 8'sd83, 1'b0, a1);
    send(20'sd30, 8'sd36, 1'b0, a2);
    send(-20'sd40, -8'sd89, 1'b1, a3);
    recv(v, lat, hi);
    checks++;
    if (v !== 32'sd3620) begin
      errors++; $display("FAIL b2b_data got=%0d exp=3620", v);
    end
    checks++;
    if (a1 - a0 !== 5 || a2 - a1 !== 5 || a3 - a2 !== 5) begin
      errors++; $display("FAIL b2b_spacing got=%0d,%0d,%0d exp=5,5,5", a1 - a0, a2 - a1, a3 - a2);
    end
    checks++;
    if (ov_rises - r0 !== 1) begin
      errors++; $display("FAIL b2b_single_valid got=%0d rises exp=1", ov_rises - r0);
    end
  endtask

  task automatic test_backpressure();
    int a, lat, hi, n, bad;
    logic signed [31:0] v;
    send(20'sd100, 8'sd3, 1'b1, a);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.in_sample = 20'sd7;
    bus.in_coef   = 8'sd3;
    bus.in_last   = 1'b1;
    bus.in_valid  = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_data !== 32'sd300 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL bp_hold got=%0d bad cycles exp=0 (data=%0d)", bad, bus.out_data);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    recv(v, lat, hi);
    checks++;
    if (v !== 32'sd21) begin
      errors++; $display("FAIL bp_next_sum got=%0d exp=21", v);
    end
  endtask

  task automatic test_random();
    int a, lat, hi, len;
    longint sum;
    logic signed [19:0] s;
    logic signed [7:0]  c;
    logic signed [31:0] v, expv;
    for (int seq = 0; seq < 10; seq++) begin
      len = int'($urandom_range(1, 4));
      sum = 0;
      for (int t = 0; t < len; t++) begin
        s = 20'($urandom);
        c = 8'($urandom);
        sum += longint'(s) * longint'(c);
        send(s, c, (t == len - 1), a);
      end
      expv = 32'(sum);
      recv(v, lat, hi);
      checks++;
      if (v !== expv) begin
        errors++; $display("FAIL random_seq%0d got=%0d exp=%0d", seq, v, expv);
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    for (int t = 0; t < 2; t++) begin
      n = 0;
      @(negedge clk);
      while (!bus16.in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      bus16.in_sample = 20'sd32767;
      bus16.in_coef   = 8'sd127;
      bus16.in_last   = (t == 1);
      bus16.in_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus16.in_valid = 1'b0;
    end
    n = 0;
    @(negedge clk);
    while (!bus16.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus16.out_valid !== 1'b1 || bus16.out_data !== -16'sd254) begin
      errors++; $display("FAIL wrap got=%0d valid=%0b exp=-254", bus16.out_data, bus16.out_valid);
    end
    bus16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus16.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int a, lat, hi;
    logic signed [31:0] v;
    send(20'sd11, 8'sd13, 1'b0, a);
    send(20'sd17, -8'sd5, 1'b0, a);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 32'sd0) begin
      errors++; $display("FAIL mid_reset got in_ready=%0b out_valid=%0b data=%0d exp 1/0/0",
                         bus.in_ready, bus.out_valid, bus.out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(20'sd5, 8'sd7, 1'b1, a);
    recv(v, lat, hi);
    checks++;
    if (v !== 32'sd35) begin
      errors++; $display("FAIL post_reset_sum got=%0d exp=35", v);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    ov_rises = 0;
    ov_prev = 1'b0;
    cyc = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sample = '0;
    bus.in_coef = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    bus16.in_valid = 1'b0;
    bus16.in_sample = '0;
    bus16.in_coef = '0;
    bus16.in_last = 1'b0;
    bus16.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_single();
    test_corners();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sau_digit_mac.md
# sau_digit_mac

Radix-8 serial multiply-accumulate engine that consumes the eight shift-and-add multiples (1x..8x) of a sample produced by an internal `sau` instance. Each accepted sample/coefficient pair is multiplied by decomposing the coefficient magnitude into octal digits, MSB first; each digit selects one `sau` multiple. Signed products are accumulated across a tap sequence terminated by `last`. It sits downstream of the sample feed in the transform datapath and replaces a hardware multiplier in each MTS butterfly lane.

## Interface
- `WIDTH`, 20, signed sample width; passed to the internal `sau`.
- `COEF_W`, 8, signed coefficient width.
- `ACC_W`, 32, accumulator and output width.
- `NDIG`, derived = ceil(COEF_W/3), number of octal digits processed per product; 3 at default.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  sample/coef/last valid.
- `in_ready`  out  1  block can accept.
- `in_sample`  in  WIDTH  signed sample.
- `in_coef`  in  COEF_W  signed coefficient.
- `in_last`  in  1  final tap of the current sum.
- `out_valid`  out  1  sum available.
- `out_ready`  in  1  downstream accepts the sum.
- `out_data`  out  ACC_W  signed accumulated sum.

## Operation
- States: IDLE, DIGIT, ACC, DONE. Reset state is IDLE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, register `in_sample` into `smp_q`, |`in_coef`| into `mag_q` (COEF_W bits unsigned), the coefficient sign into `neg_q` and `in_last` into `last_q`. Clear `part_q`, load digit counter `dig_q`=NDIG-1, then go to DIGIT.
- `sau` input is `smp_q`; its outputs `m[0..7]` equal (k+1)·`smp_q`, each WIDTH+3 bits wide.
- DIGIT: d = `mag_q`[3·dig_q+2 : 3·dig_q], with the high bits zero-padded. Term = 0 if d=0, else `m[d-1]`. Update `part_q` <= (`part_q`<<3) + term. `part_q` is WIDTH+COEF_W bits signed, which is exact for all inputs. When `dig_q`=0, go to ACC; otherwise decrement `dig_q`.
- ACC: `acc_q` <= `acc_q` ± sext(`part_q`), using minus when `neg_q`. The sum wraps modulo 2^ACC_W; there is no saturation.
  - If `last_q`=0, go to IDLE.
  - If `last_q`=1, `out_data` <= the new sum, `acc_q` <= 0, go to DONE.
- DONE: `out_valid`=1 and `in_ready`=0. `out_data` is held stable. On `out_ready`, go to IDLE.
- Coefficient -2^(COEF_W-1), i.e. -128, has magnitude 128 = octal 200 and is handled exactly.
- An input offered outside IDLE is not accepted. `in_valid` may drop or change freely while `in_ready`=0.
- Reset asserted in any state (async) returns to IDLE:
  - `acc_q`, `part_q` and `out_data` cleared, `out_valid`=0.
  - Any in-flight product and partial sum are discarded.

## Timing
- Reset values: `in_ready`=1 (IDLE decode), `out_valid`=0, `out_data`=0.
- Accept at edge T. DIGIT occupies cycles T+1..T+NDIG. ACC occupies cycle T+NDIG+1.
- Non-last tap: `in_ready` returns to 1 at cycle T+NDIG+2. Throughput is one tap per NDIG+2 cycles (5 at default).
- Last tap: `out_valid` rises at cycle T+NDIG+2 and holds until the `out_ready` edge. `in_ready` rises the cycle after the handshake.
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.

## Test plan
- Single tap `in_sample`=1000, `in_coef`=90, `in_last`=1 -> `out_data`=90000, `out_valid` high exactly 5 cycles after accept; `in_ready` low during cycles 1-5.
- Single tap `in_sample`=-3, `in_coef`=-128 -> `out_data`=384. Then `in_sample`=524287, `in_coef`=127 -> 66584449. Then `in_coef`=0 -> 0.
- Four taps (10,64), (-20,83), (30,36), (-40,-89) with `last` on the fourth -> single `out_valid`, `out_data`=3620; accepts are spaced 5 cycles apart.
- Backpressure: hold `out_ready`=0 for 10 cycles with `in_valid`=1 -> `out_data` stable, `in_ready`=0, no extra accept. Release -> the next sum is computed from a cleared accumulator.
- Wrap: ACC_W=16 override, taps (32767,127)x2 with last -> `out_data`=(2·32767·127) mod 2^16 interpreted signed = -254.
- Assert `rst_n` low mid-DIGIT of tap 2 of a sequence -> `out_valid`=0, `in_ready`=1 immediately. Afterwards, single tap (5,7,last) -> `out_data`=35 with no residue from before reset.
